// File: rtl/riscv_timer.sv
`default_nettype none
// ============================================================================
// Module   : riscv_timer
// Brief    : Memory-mapped machine timer (mtime / mtimecmp / ctrl) on the
//            hart data-memory port. Combinational read word, byte/half/word
//            store lane merge, one-cycle timer_irq pulse on first match.
//            Optional prescaler: define RISCV_TIMER_PRESCALER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [2:0]  mem_op,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        timer_irq
);

  // Word index of each register inside the 32-byte window
  localparam logic [2:0] c_IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] c_IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] c_IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] c_IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] c_IDX_CTRL     = 3'd4;

  localparam logic [1:0] c_SZ_BYTE = 2'd1;
  localparam logic [1:0] c_SZ_HALF = 2'd2;
  localparam logic [1:0] c_SZ_WORD = 2'd3;

  // Registered state
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_en;
  logic        r_match_q;
  logic        r_timer_irq;

  // Decode and store datapath
  logic [1:0]  w_size;
  logic [2:0]  w_idx;
  logic        w_misaligned;
  logic        w_store;
  logic [3:0]  w_be;
  logic [31:0] w_wlane;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_ctrl;
  logic        w_tick;
  logic [7:0]  w_prescale_rd;
  logic [63:0] w_mtime_inc;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_mtimecmp_nxt;
  logic        w_match;

  // Replace the byte lanes selected by be with the new data
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

  assign w_size = mem_op[1:0];
  assign w_idx  = addr[4:2];
  assign sel    = (addr[31:5] == BASE_ADDR[31:5]) && (w_size != 2'd0);

  // Misaligned stores are dropped here; the hart raises the trap itself
  assign w_misaligned = ((w_size == c_SZ_HALF) && addr[0]) ||
                        ((w_size == c_SZ_WORD) && (addr[1:0] != 2'b00));
  assign w_store      = sel && mem_op[2] && !w_misaligned;

  // Byte enables and lane-replicated store data from the right-aligned bus
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = wdata;
    case (w_size)
      c_SZ_BYTE: begin
        w_be[addr[1:0]] = 1'b1;
        w_wlane         = {4{wdata[7:0]}};
      end
      c_SZ_HALF: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{wdata[15:0]}};
      end
      c_SZ_WORD: begin
        w_be    = 4'b1111;
        w_wlane = wdata;
      end
      default: begin
        w_be    = 4'b0000;
        w_wlane = wdata;
      end
    endcase
  end

  assign w_wr_mtime_lo = w_store && (w_idx == c_IDX_MTIME_LO);
  assign w_wr_mtime_hi = w_store && (w_idx == c_IDX_MTIME_HI);
  assign w_wr_cmp_lo   = w_store && (w_idx == c_IDX_CMP_LO);
  assign w_wr_cmp_hi   = w_store && (w_idx == c_IDX_CMP_HI);
  assign w_wr_ctrl     = w_store && (w_idx == c_IDX_CTRL);

`ifdef RISCV_TIMER_PRESCALER_EN
  logic [7:0] r_prescale;
  logic [7:0] r_pcnt;

  assign w_tick        = r_en && (r_pcnt == r_prescale);
  assign w_prescale_rd = r_prescale;

  // Prescale field and counter; any ctrl store restarts the period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= 8'd0;
      r_pcnt     <= 8'd0;
    end else begin
      if (w_wr_ctrl && w_be[1]) r_prescale <= w_wlane[15:8];
      if (w_wr_ctrl)            r_pcnt     <= 8'd0;
      else if (w_tick)          r_pcnt     <= 8'd0;
      else if (r_en)            r_pcnt     <= r_pcnt + 8'd1;
    end
  end
`else
  assign w_tick        = r_en;
  assign w_prescale_rd = 8'd0;
`endif

  assign w_mtime_inc = r_mtime + 64'd1;

  // mtime next value: a store to one half wins over the tick for that half
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr_mtime_lo) begin
      // Lo store blocks the increment, so no carry reaches hi either
      w_mtime_nxt[31:0] = merge_lanes(r_mtime[31:0], w_wlane, w_be);
    end else if (w_wr_mtime_hi) begin
      // Hi store: lo still counts, its carry out is discarded
      w_mtime_nxt[63:32] = merge_lanes(r_mtime[63:32], w_wlane, w_be);
      if (w_tick) w_mtime_nxt[31:0] = w_mtime_inc[31:0];
    end else if (w_tick) begin
      w_mtime_nxt = w_mtime_inc;
    end
  end

  // mtimecmp next value from lane-merged stores
  always_comb begin
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_wr_cmp_lo)
      w_mtimecmp_nxt[31:0]  = merge_lanes(r_mtimecmp[31:0], w_wlane, w_be);
    if (w_wr_cmp_hi)
      w_mtimecmp_nxt[63:32] = merge_lanes(r_mtimecmp[63:32], w_wlane, w_be);
  end

  // Counter, compare and enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= {64{1'b1}};
      r_en       <= 1'b1;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      if (w_wr_ctrl && w_be[0]) r_en <= w_wlane[0];
    end
  end

  assign w_match = (r_mtime >= r_mtimecmp);

  // Rising-edge detector on match gives a single-cycle interrupt pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_q   <= 1'b0;
      r_timer_irq <= 1'b0;
    end else begin
      r_match_q   <= w_match;
      r_timer_irq <= w_match && !r_match_q;
    end
  end

  assign timer_irq = r_timer_irq;

  // Combinational read word, zero when the access is not for this block
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (w_idx)
        c_IDX_MTIME_LO: rdata = r_mtime[31:0];
        c_IDX_MTIME_HI: rdata = r_mtime[63:32];
        c_IDX_CMP_LO:   rdata = r_mtimecmp[31:0];
        c_IDX_CMP_HI:   rdata = r_mtimecmp[63:32];
        c_IDX_CTRL:     rdata = {w_match, 15'd0, w_prescale_rd, 7'd0, r_en};
        default:        rdata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_timer
// Brief    : Directed self-checking bench for riscv_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_timer;

  localparam logic [31:0] c_BASE = 32'h0200_0000;
  localparam logic [2:0]  c_LD_W = 3'b011;
  localparam logic [2:0]  c_ST_B = 3'b101;
  localparam logic [2:0]  c_ST_H = 3'b110;
  localparam logic [2:0]  c_ST_W = 3'b111;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [2:0]  mem_op;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;
  logic        timer_irq;

  int n_checks;
  int n_fail;

  riscv_timer #(.BASE_ADDR(c_BASE)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .mem_op    (mem_op),
    .wdata     (wdata),
    .rdata     (rdata),
    .sel       (sel),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One store in a single cycle, driven on the falling edge
  task automatic bus_wr(input logic [4:0] off, input logic [2:0] op, input logic [31:0] d);
    @(negedge clk);
    addr   = c_BASE | {27'd0, off};
    mem_op = op;
    wdata  = d;
    @(posedge clk);
    #1;
    mem_op = 3'b000;
  endtask

  // One word load in the next cycle, sampled mid-cycle
  task automatic bus_rd(input logic [4:0] off, output logic [31:0] d);
    @(negedge clk);
    addr   = c_BASE | {27'd0, off};
    mem_op = c_LD_W;
    #1;
    d      = rdata;
    mem_op = 3'b000;
  endtask

  logic [31:0] v;
  int          t100;
  int          tirq;
  int          nirq;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    addr     = 32'd0;
    mem_op   = 3'b000;
    wdata    = 32'd0;
    repeat (3) @(negedge clk);
    check("irq_in_reset", {31'd0, timer_irq}, 32'd0);
    rst_n = 1'b1;

    // Reset values
    bus_rd(5'h08, v); check("rst_cmp_lo", v, 32'hFFFF_FFFF);
    bus_rd(5'h0C, v); check("rst_cmp_hi", v, 32'hFFFF_FFFF);
    bus_rd(5'h10, v); check("rst_ctrl", v, 32'h0000_0001);
    check("irq_after_rst", {31'd0, timer_irq}, 32'd0);

    // Decode: outside window and op none
    @(negedge clk);
    addr = c_BASE + 32'h20; mem_op = c_LD_W; #1;
    check("sel_out_of_window", {31'd0, sel}, 32'd0);
    check("rdata_unsel", rdata, 32'd0);
    addr = c_BASE + 32'h08; mem_op = 3'b000; #1;
    check("sel_op_none", {31'd0, sel}, 32'd0);
    mem_op = c_LD_W; #1;
    check("sel_in_window", {31'd0, sel}, 32'd1);
    mem_op = 3'b000;

    // Lane merge and misaligned suppression
    bus_wr(5'h09, c_ST_B, 32'h0000_00AB);
    bus_rd(5'h08, v); check("byte_st_cmp", v, 32'hFFFF_ABFF);
    bus_wr(5'h0B, c_ST_H, 32'h0000_1234);
    bus_rd(5'h08, v); check("half_misaligned", v, 32'hFFFF_ABFF);
    bus_wr(5'h0A, c_ST_W, 32'h0000_0000);
    bus_rd(5'h08, v); check("word_misaligned", v, 32'hFFFF_ABFF);
    bus_wr(5'h0A, c_ST_H, 32'h0000_1234);
    bus_rd(5'h08, v); check("half_st_hi", v, 32'h1234_ABFF);
    bus_rd(5'h1C, v); check("reserved_rd", v, 32'd0);

    // Stop the timer, then one tick carries lo into hi
    bus_wr(5'h10, c_ST_W, 32'h0);
    bus_wr(5'h00, c_ST_W, 32'hFFFF_FFFF);
    bus_wr(5'h04, c_ST_W, 32'h0);
    bus_rd(5'h00, v); check("mtime_lo_wr", v, 32'hFFFF_FFFF);
    bus_rd(5'h04, v); check("mtime_hi_wr", v, 32'h0);
    bus_wr(5'h10, c_ST_W, 32'h1);
    bus_wr(5'h10, c_ST_W, 32'h0);
    bus_rd(5'h00, v); check("carry_lo", v, 32'h0);
    bus_rd(5'h04, v); check("carry_hi", v, 32'h1);

    // 64-bit wrap
    bus_wr(5'h00, c_ST_W, 32'hFFFF_FFFF);
    bus_wr(5'h04, c_ST_W, 32'hFFFF_FFFF);
    bus_wr(5'h10, c_ST_W, 32'h1);
    bus_wr(5'h10, c_ST_W, 32'h0);
    bus_rd(5'h00, v); check("wrap_lo", v, 32'h0);
    bus_rd(5'h04, v); check("wrap_hi", v, 32'h0);

    // Lo word store coincident with tick: no increment, no carry
    bus_wr(5'h04, c_ST_W, 32'h5);
    bus_wr(5'h00, c_ST_W, 32'h0);
    bus_wr(5'h10, c_ST_W, 32'h1);
    bus_wr(5'h00, c_ST_W, 32'hFFFF_FFFF);
    bus_wr(5'h10, c_ST_W, 32'h0);
    bus_rd(5'h00, v); check("lo_tick_lo", v, 32'h0);
    bus_rd(5'h04, v); check("lo_tick_hi", v, 32'h6);

    // Lo byte store coincident with tick: other lanes hold
    bus_wr(5'h04, c_ST_W, 32'h0);
    bus_wr(5'h00, c_ST_W, 32'h1122_3344);
    bus_wr(5'h10, c_ST_W, 32'h1);
    bus_wr(5'h01, c_ST_B, 32'h0000_00AA);
    bus_wr(5'h10, c_ST_W, 32'h0);
    bus_rd(5'h00, v); check("lo_byte_tick", v, 32'h1122_AA45);

    // Hi store coincident with tick: lo increments, carry discarded
    bus_wr(5'h04, c_ST_W, 32'h3);
    bus_wr(5'h00, c_ST_W, 32'hFFFF_FFFF);
    bus_wr(5'h10, c_ST_W, 32'h1);
    bus_wr(5'h04, c_ST_W, 32'h20);
    bus_wr(5'h10, c_ST_W, 32'h0);
    bus_rd(5'h00, v); check("hi_tick_lo", v, 32'h1);
    bus_rd(5'h04, v); check("hi_tick_hi", v, 32'h20);

    // Prescale field
    bus_wr(5'h10, c_ST_W, 32'h0000_5500);
    bus_rd(5'h10, v);
`ifdef RISCV_TIMER_PRESCALER_EN
    check("ctrl_prescale_rd", {16'd0, v[15:0]}, 32'h0000_5500);
`else
    check("ctrl_prescale_rd", {16'd0, v[15:0]}, 32'h0000_0000);
`endif

`ifdef RISCV_TIMER_PRESCALER_EN
    // prescale=3: one increment every 4 cycles, ctrl store restarts period
    bus_wr(5'h00, c_ST_W, 32'h0);
    bus_wr(5'h04, c_ST_W, 32'h0);
    bus_wr(5'h10, c_ST_W, 32'h0000_0301);
    for (int i = 0; i < 8; i++) begin
      bus_rd(5'h00, v);
      check($sformatf("presc_c%0d", i + 1), v, (i >= 4) ? 32'd1 : 32'd0);
    end
    bus_rd(5'h00, v); check("presc_c9", v, 32'd2);
    bus_rd(5'h00, v); check("presc_c10", v, 32'd2);
    bus_wr(5'h10, c_ST_W, 32'h0000_0301);
    for (int i = 0; i < 5; i++) begin
      bus_rd(5'h00, v);
      check($sformatf("presc_restart_c%0d", i + 1), v, (i == 4) ? 32'd3 : 32'd2);
    end
    bus_wr(5'h10, c_ST_W, 32'h0);
`endif

    // Compare {0,100} from mtime 0: exactly one pulse, one cycle after 100
    bus_wr(5'h00, c_ST_W, 32'h0);
    bus_wr(5'h04, c_ST_W, 32'h0);
    bus_wr(5'h08, c_ST_W, 32'd100);
    bus_wr(5'h0C, c_ST_W, 32'h0);
    bus_rd(5'h10, v); check("no_match_before", {31'd0, v[31]}, 32'd0);
    t100 = -1;
    tirq = -1;
    nirq = 0;
    bus_wr(5'h10, c_ST_W, 32'h1);
    for (int i = 0; i < 150; i++) begin
      bus_rd(5'h00, v);
      if (v == 32'd100 && t100 < 0) t100 = i;
      if (timer_irq) begin
        nirq++;
        if (tirq < 0) tirq = i;
      end
    end
    check("irq_count", nirq, 32'd1);
    check("irq_time", tirq, t100 + 1);
    bus_wr(5'h10, c_ST_W, 32'h0);
    bus_rd(5'h10, v); check("pending_after", {31'd0, v[31]}, 32'd1);

    // Re-arm by moving cmp away and back, then reset during the pulse
    bus_wr(5'h0C, c_ST_W, 32'hFFFF_FFFF);
    bus_wr(5'h0C, c_ST_W, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("irq_rearm", {31'd0, timer_irq}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("irq_async_clr", {31'd0, timer_irq}, 32'd0);
    bus_rd(5'h00, v); check("rst2_mtime_lo", v, 32'h0);
    bus_rd(5'h04, v); check("rst2_mtime_hi", v, 32'h0);
    bus_rd(5'h08, v); check("rst2_cmp_lo", v, 32'hFFFF_FFFF);
    bus_rd(5'h0C, v); check("rst2_cmp_hi", v, 32'hFFFF_FFFF);
    bus_rd(5'h10, v); check("rst2_ctrl", v, 32'h0000_0001);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("irq_after_rst2", {31'd0, timer_irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
